// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter that shares one SPI byte transmitter between the OLED
// sub-engines, with per-requester burst lock and a spi_done watchdog.
module oled_spi_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 4095
) (
    input  logic              clkin_50m,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_dc,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              spi_send,
    output logic [7:0]        spi_data,
    output logic              spi_dc,
    input  logic              spi_done,
    output logic              busy,
    output logic              timeout_err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_ACK, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] own_q, own_d;
    logic [IW-1:0] own_nxt, win, cand;
    logic          win_vld;
    logic [11:0]   timer_q, timer_d;
    logic          done_q, done_rise;
    logic [7:0]    data_q, data_d;
    logic          dc_q, dc_d;
    logic          terr_q, terr_d;

    // Scan downward so the requester closest above ptr is the last one written.
    always_comb begin
        win     = ptr_q;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign own_nxt   = (own_q == IW'(NREQ - 1)) ? '0 : own_q + IW'(1);
    assign done_rise = spi_done & ~done_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        timer_d = timer_q;
        data_d  = data_q;
        dc_d    = dc_q;
        terr_d  = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    own_d   = win;
                    data_d  = req_data[{win, 3'b000} +: 8];
                    dc_d    = req_dc[win];
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done edge wins over a simultaneous watchdog expiry.
                if (done_rise) begin
                    state_d = S_ACK;
                end else if (timer_q == 12'(TIMEOUT)) begin
                    terr_d  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end
            S_ACK: begin
                if (lock[own_q]) begin
                    state_d = S_HOLD;
                end else begin
                    ptr_d   = own_nxt;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (req[own_q]) begin
                    data_d  = req_data[{own_q, 3'b000} +: 8];
                    dc_d    = req_dc[own_q];
                    state_d = S_SEND;
                end else if (!lock[own_q]) begin
                    ptr_d   = own_nxt;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkin_50m) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            dc_q    <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            timer_q <= timer_d;
            done_q  <= spi_done;
            data_q  <= data_d;
            dc_q    <= dc_d;
            terr_q  <= terr_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign grant       = busy ? (NREQ'(1) << own_q) : '0;
    assign ack         = (state_q == S_ACK) ? grant : '0;
    assign spi_send    = (state_q == S_SEND);
    assign spi_data    = data_q;
    assign spi_dc      = dc_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Self-checking bench for oled_spi_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin/lock model.
module tb_oled_spi_arbiter;
    localparam int NREQ = 3;
    localparam int TO   = 16;

    logic        clkin_50m = 1'b0;
    logic        reset     = 1'b1;
    logic [2:0]  req       = '0;
    logic [2:0]  lock      = '0;
    logic [23:0] req_data  = '0;
    logic [2:0]  req_dc    = '0;
    logic        spi_done  = 1'b0;
    logic [2:0]  ack, grant;
    logic        spi_send, spi_dc, busy, timeout_err;
    logic [7:0]  spi_data;

    int errs   = 0;
    int checks = 0;
    int m_ptr  = 0;

    logic [7:0] t_dat [3][8];
    logic       t_dc  [3][8];
    logic       t_lk  [3][8];
    int         t_cnt [3];
    int         t_pos [3];
    logic [2:0] obs_g [$];

    oled_spi_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clkin_50m(clkin_50m), .reset(reset), .req(req), .lock(lock),
        .req_data(req_data), .req_dc(req_dc), .ack(ack), .grant(grant),
        .spi_send(spi_send), .spi_data(spi_data), .spi_dc(spi_dc),
        .spi_done(spi_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #10 clkin_50m = ~clkin_50m;

    function automatic logic [2:0] oh(input int i);
        return 3'b001 << i;
    endfunction

    function automatic void drive_traffic();
        for (int j = 0; j < NREQ; j++) begin
            if (t_pos[j] < t_cnt[j]) begin
                req[j]              = 1'b1;
                req_data[8*j +: 8]  = t_dat[j][t_pos[j]];
                req_dc[j]           = t_dc[j][t_pos[j]];
                lock[j]             = t_lk[j][t_pos[j]];
            end else begin
                req[j]  = 1'b0;
                lock[j] = 1'b0;
            end
        end
    endfunction

    task automatic do_reset();
        @(posedge clkin_50m); #1;
        reset = 1'b1; req = '0; lock = '0; spi_done = 1'b0;
        repeat (2) @(posedge clkin_50m);
        #1 reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic wait_send(input string name, output bit found);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clkin_50m);
            if (spi_send === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin errs++; $display("FAIL %s: no spi_send within 10 cycles", name); end
    endtask

    // Model: owner keeps the grant while its byte carries lock and it has more
    // bytes; otherwise the first pending requester at or above ptr wins.
    task automatic run_traffic(input string name);
        int eg[32]; logic [7:0] ed[32]; logic ec[32];
        int rem[3]; int total, hold, p, g, idx, n_tx, n_ack, dly, gi;
        total = 0; hold = -1; p = m_ptr;
        for (int j = 0; j < NREQ; j++) begin rem[j] = t_cnt[j]; total += t_cnt[j]; t_pos[j] = 0; end
        for (int n = 0; n < total; n++) begin
            g = -1;
            if (hold >= 0) g = hold;
            else for (int k = 0; k < NREQ; k++) if (g < 0 && rem[(p + k) % NREQ] > 0) g = (p + k) % NREQ;
            idx = t_cnt[g] - rem[g];
            eg[n] = g; ed[n] = t_dat[g][idx]; ec[n] = t_dc[g][idx];
            hold = (t_lk[g][idx] && rem[g] > 1) ? g : -1;
            if (hold < 0) p = (g + 1) % NREQ;
            rem[g]--;
        end
        obs_g.delete();
        n_tx = 0; n_ack = 0; dly = -1;
        @(posedge clkin_50m); #1;
        drive_traffic();
        for (int c = 0; c < 800 && n_ack < total; c++) begin
            @(negedge clkin_50m);
            if (spi_send === 1'b1) begin
                checks++;
                if (n_tx >= total) begin
                    errs++; $display("FAIL %s send: extra spi_send, grant %b", name, grant);
                end else if (grant !== oh(eg[n_tx]) || spi_data !== ed[n_tx] || spi_dc !== ec[n_tx]) begin
                    errs++;
                    $display("FAIL %s send#%0d: got grant %b data %h dc %b want %b %h %b",
                             name, n_tx, grant, spi_data, spi_dc, oh(eg[n_tx]), ed[n_tx], ec[n_tx]);
                end
                obs_g.push_back(grant);
                n_tx++;
                dly = int'($urandom_range(0, 5));
            end
            if (ack !== 3'b000) begin
                checks++;
                if (n_ack >= total) begin
                    errs++; $display("FAIL %s ack: extra ack %b", name, ack);
                end else if (ack !== oh(eg[n_ack]) || spi_data !== ed[n_ack]) begin
                    errs++;
                    $display("FAIL %s ack#%0d: got ack %b data %h want %b %h",
                             name, n_ack, ack, spi_data, oh(eg[n_ack]), ed[n_ack]);
                end
                gi = 0;
                for (int j = 0; j < NREQ; j++) if (ack[j]) gi = j;
                t_pos[gi]++;
                n_ack++;
            end
            @(posedge clkin_50m); #1;
            spi_done = 1'b0;
            if (dly == 0) begin spi_done = 1'b1; dly = -1; end
            else if (dly > 0) dly--;
            drive_traffic();
        end
        checks++;
        if (n_ack != total || n_tx != total) begin
            errs++; $display("FAIL %s count: got %0d sends %0d acks want %0d", name, n_tx, n_ack, total);
        end
        m_ptr = p;
        req = '0; lock = '0;
    endtask

    task automatic test_reset();
        @(posedge clkin_50m); #1 reset = 1'b1;
        @(posedge clkin_50m);
        @(negedge clkin_50m);
        checks++;
        if (grant !== 3'b000 || ack !== 3'b000 || spi_send !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL reset ctl: got grant %b ack %b send %b busy %b want 000 000 0 0", grant, ack, spi_send, busy);
        end
        checks++;
        if (spi_data !== 8'h00 || spi_dc !== 1'b0 || timeout_err !== 1'b0) begin
            errs++; $display("FAIL reset data: got %h %b err %b want 00 0 0", spi_data, spi_dc, timeout_err);
        end
        #1 reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        @(posedge clkin_50m); #1;
        req = 3'b010; req_data[15:8] = 8'hAE; req_dc = 3'b000; lock = '0;
        @(negedge clkin_50m);
        @(negedge clkin_50m);
        checks++;
        if (spi_send !== 1'b1 || spi_data !== 8'hAE || spi_dc !== 1'b0 || grant !== 3'b010) begin
            errs++; $display("FAIL single send: got send %b data %h dc %b grant %b want 1 ae 0 010", spi_send, spi_data, spi_dc, grant);
        end
        // Done kept inside the TIMEOUT=16 window of this bench's instance.
        repeat (11) @(posedge clkin_50m);
        #1 spi_done = 1'b1;
        @(negedge clkin_50m);
        checks++;
        if (ack !== 3'b000) begin errs++; $display("FAIL single early ack: got %b want 000", ack); end
        @(posedge clkin_50m); #1 spi_done = 1'b0;
        @(negedge clkin_50m);
        checks++;
        if (ack !== 3'b010) begin errs++; $display("FAIL single ack: got %b want 010", ack); end
        @(posedge clkin_50m); #1 req = 3'b000;
        @(negedge clkin_50m);
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0 || ack !== 3'b000) begin
            errs++; $display("FAIL single idle: got grant %b busy %b ack %b want 000 0 000", grant, busy, ack);
        end
        m_ptr = 2;
    endtask

    task automatic test_burst_lock();
        logic [2:0] want [5];
        want = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001};
        t_cnt = '{2, 0, 3};
        t_dat[0][0] = 8'h11; t_dat[0][1] = 8'h22; t_dc[0][0] = 1; t_dc[0][1] = 1; t_lk[0][0] = 0; t_lk[0][1] = 0;
        t_dat[2][0] = 8'hB0; t_dat[2][1] = 8'h10; t_dat[2][2] = 8'h00;
        t_dc[2][0] = 0; t_dc[2][1] = 0; t_dc[2][2] = 0;
        t_lk[2][0] = 1; t_lk[2][1] = 1; t_lk[2][2] = 0;
        run_traffic("burst");
        checks++;
        if (obs_g.size() != 5) begin
            errs++; $display("FAIL burst order: got %0d grants want 5", obs_g.size());
        end else begin
            for (int i = 0; i < 5; i++)
                if (obs_g[i] !== want[i]) begin
                    errs++; $display("FAIL burst order[%0d]: got %b want %b", i, obs_g[i], want[i]);
                    break;
                end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want [4];
        want = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        t_cnt = '{2, 2, 2};
        for (int j = 0; j < NREQ; j++)
            for (int i = 0; i < 2; i++) begin
                t_dat[j][i] = 8'(16 * (j + 1) + i); t_dc[j][i] = 1'(i); t_lk[j][i] = 1'b0;
            end
        run_traffic("rr");
        checks++;
        if (obs_g.size() < 4) begin
            errs++; $display("FAIL rr order: got %0d grants want 6", obs_g.size());
        end else begin
            for (int i = 0; i < 4; i++)
                if (obs_g[i] !== want[i]) begin
                    errs++; $display("FAIL rr order[%0d]: got %b want %b", i, obs_g[i], want[i]);
                    break;
                end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < NREQ; j++) begin
                t_cnt[j] = int'($urandom_range(0, 5));
                for (int i = 0; i < 8; i++) begin
                    t_dat[j][i] = 8'($urandom);
                    t_dc[j][i]  = 1'($urandom_range(0, 1));
                    t_lk[j][i]  = 1'($urandom_range(0, 1));
                end
            end
            run_traffic("random");
        end
        checks++;
        if (timeout_err !== 1'b0) begin errs++; $display("FAIL random terr: got %b want 0", timeout_err); end
    endtask

    task automatic test_watchdog();
        bit found; int ackat;
        @(posedge clkin_50m); #1;
        spi_done = 1'b0; req = 3'b001; req_data[7:0] = 8'h5A; lock = '0;
        wait_send("wd", found);
        ackat = -1;
        for (int i = 1; i <= 40 && ackat < 0; i++) begin
            @(negedge clkin_50m);
            if (ack !== 3'b000) ackat = i;
        end
        checks++;
        if (ackat != TO + 2) begin errs++; $display("FAIL wd latency: got %0d want %0d", ackat, TO + 2); end
        @(posedge clkin_50m); #1 req = '0;
        @(negedge clkin_50m);
        checks++;
        if (timeout_err !== 1'b1) begin errs++; $display("FAIL wd terr: got %b want 1", timeout_err); end
        m_ptr = 1;
        t_cnt = '{0, 1, 1};
        t_dat[1][0] = 8'h33; t_dc[1][0] = 1; t_lk[1][0] = 0;
        t_dat[2][0] = 8'h44; t_dc[2][0] = 0; t_lk[2][0] = 0;
        run_traffic("wd_after");
        checks++;
        if (timeout_err !== 1'b1) begin errs++; $display("FAIL wd sticky: got %b want 1", timeout_err); end

        do_reset();
        @(negedge clkin_50m);
        checks++;
        if (timeout_err !== 1'b0) begin errs++; $display("FAIL wd clear: got %b want 0", timeout_err); end
        @(posedge clkin_50m); #1 req = 3'b001;
        wait_send("wd_edge", found);
        ackat = -1;
        for (int i = 1; i <= 40 && ackat < 0; i++) begin
            @(posedge clkin_50m); #1 spi_done = (i == TO + 1);
            @(negedge clkin_50m);
            if (ack !== 3'b000) ackat = i;
        end
        @(posedge clkin_50m); #1 req = '0; spi_done = 1'b0;
        @(negedge clkin_50m);
        checks++;
        if (ackat != TO + 2 || timeout_err !== 1'b0) begin
            errs++; $display("FAIL wd coincident: got ack at %0d err %b want %0d 0", ackat, timeout_err, TO + 2);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit found, bad;
        do_reset();
        t_cnt = '{1, 0, 0};
        t_dat[0][0] = 8'h77; t_dc[0][0] = 0; t_lk[0][0] = 0;
        run_traffic("rst_pre");
        @(posedge clkin_50m); #1;
        req = 3'b100; req_data[23:16] = 8'hC3; req_dc = 3'b100;
        wait_send("rst", found);
        repeat (3) @(posedge clkin_50m);
        #1 reset = 1'b1; req = '0;
        @(posedge clkin_50m); #1 reset = 1'b0;
        @(negedge clkin_50m);
        checks++;
        if (busy !== 1'b0 || grant !== 3'b000 || ack !== 3'b000 || spi_send !== 1'b0 ||
            spi_data !== 8'h00 || spi_dc !== 1'b0 || timeout_err !== 1'b0) begin
            errs++; $display("FAIL rst outputs: got busy %b grant %b ack %b send %b data %h dc %b err %b want all zero",
                             busy, grant, ack, spi_send, spi_data, spi_dc, timeout_err);
        end
        bad = 1'b0;
        @(posedge clkin_50m); #1 spi_done = 1'b1;
        @(posedge clkin_50m); #1 spi_done = 1'b0;
        repeat (5) begin
            @(negedge clkin_50m);
            if (ack !== 3'b000 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errs++; $display("FAIL rst late done: got ack or busy after abandoned transfer want none"); end
        @(posedge clkin_50m); #1;
        req = 3'b101; req_data[7:0] = 8'h11; req_data[23:16] = 8'h22; req_dc = '0;
        wait_send("rst_ptr", found);
        checks++;
        if (grant !== 3'b001 || spi_data !== 8'h11) begin
            errs++; $display("FAIL rst ptr: got grant %b data %h want 001 11", grant, spi_data);
        end
        @(posedge clkin_50m); #1 spi_done = 1'b1; req = 3'b000;
        @(posedge clkin_50m); #1 spi_done = 1'b0;
        repeat (3) @(posedge clkin_50m);
    endtask

    task automatic test_stale_done();
        bit found, bad; int ackat;
        do_reset();
        @(posedge clkin_50m); #1 spi_done = 1'b1;
        repeat (3) @(posedge clkin_50m);
        #1 req = 3'b001; req_data[7:0] = 8'h99;
        wait_send("stale", found);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clkin_50m);
            if (ack !== 3'b000) bad = 1'b1;
        end
        checks++;
        if (bad) begin errs++; $display("FAIL stale ack: got ack with done held high want none"); end
        @(posedge clkin_50m); #1 spi_done = 1'b0;
        @(posedge clkin_50m); #1 spi_done = 1'b1;
        ackat = -1;
        for (int i = 0; i < 4 && ackat < 0; i++) begin
            @(negedge clkin_50m);
            if (ack !== 3'b000) ackat = i;
            @(posedge clkin_50m); #1;
        end
        req = '0; spi_done = 1'b0;
        checks++;
        if (ackat != 1) begin errs++; $display("FAIL stale rise: got ack at %0d want 1", ackat); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_lock();
        test_round_robin();
        test_random();
        test_watchdog();
        test_reset_mid_wait();
        test_stale_done();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
